mult_shift_add_seq: RTL and testbench
=====================================

MULT_SHIFT_ADD_SEQ -- requirements
Module: mult_shift_add_seq

Interface
REQ-001 Parameters SHALL be: none; operand width is fixed at 8 bits.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Run  input  1  level start request; start taken when high in IDLE.
REQ-005 ClearA_LoadB  input  1  in IDLE: load B from S, clear A and X.
REQ-006 S  input  8  operand switches: multiplier source for load, multiplicand at start.
REQ-007 Aval  output  8  A register, product high byte.
REQ-008 Bval  output  8  B register, product low byte.
REQ-009 X  output  1  sign-extension bit of A.
REQ-010 Busy  output  1  high while in COMPUTE.
REQ-011 Done  output  1  high while in HOLD.

Function
REQ-012 Operands and product SHALL be two's-complement signed; product = {Aval,Bval}, 16 bits.
REQ-013 FSM states SHALL be IDLE, COMPUTE, HOLD.
REQ-014 IDLE, ClearA_LoadB=1, Run=0: next edge B<=S, A<=0, X<=0.
REQ-015 IDLE, Run=1: next edge SHALL capture S into internal Sreg, clear A and X, zero the 3-bit iteration counter k, and enter COMPUTE; Run has priority over ClearA_LoadB.
REQ-016 COMPUTE, each cycle, with the current {X,A} and B[0] as operands: if B[0]=1, {X,A} SHALL become the 9-bit sum {A[7],A} + {Sreg[7],Sreg} when k<7, or the difference {A[7],A} - {Sreg[7],Sreg} when k=7; else {X,A} SHALL be unchanged.
REQ-017 Within the same cycle the result SHALL be arithmetically shifted right one bit: X kept, A <= {X,A[7:1]}, B <= {A[0],B[7:1]}, all using post-add values.
REQ-018 Carry out of bit 8 SHALL be discarded.
REQ-019 The 9-bit add/subtract SHALL be a ripple chain of the team's one-bit full_adder cells; subtract = invert operand, carry-in 1.
REQ-020 k SHALL increment each COMPUTE cycle; after the k=7 cycle the FSM SHALL enter HOLD, giving exactly 8 COMPUTE cycles (Run edge to Done high = 9 edges).
REQ-021 HOLD SHALL keep all registers stable; Run=0 returns to IDLE; Run held high stays in HOLD (no auto-restart).
REQ-022 Run and ClearA_LoadB SHALL be ignored in COMPUTE; S changes in COMPUTE SHALL not affect the result.
REQ-023 A new Run from IDLE without reload SHALL multiply the current B (previous low byte) by the new S.
REQ-024 Busy and Done SHALL be registered-state decodes, never simultaneously high.

Reset
REQ-025 Reset_n=0 SHALL immediately force IDLE, A=B=Sreg=0, X=0, k=0, Busy=0, Done=0, regardless of clock.
REQ-026 Reset mid-COMPUTE SHALL abort the operation with no partial result retained; first action after release requires a new Run or load.
REQ-027 Reset release SHALL be synchronized to Clk by the integrator; the block assumes a clean deassertion edge.

Verification
REQ-028 Load B=0x03, S=0x07, Run -> after 9 edges Done=1, {Aval,Bval}=0x0015, X=0.
REQ-029 Load B=0xFD, S=0x07, Run -> {Aval,Bval}=0xFFEB, X=1.
REQ-030 Load B=0x80, S=0x80, Run -> {Aval,Bval}=0x4000, X=0; load B=0x7F, S=0x80, Run -> 0xC080, X=1.
REQ-031 Run held high 20 cycles -> Busy exactly 8 cycles, then Done stays 1, registers stable; Run low -> IDLE next edge.
REQ-032 Toggle S and ClearA_LoadB during COMPUTE -> result identical to the undisturbed case.
REQ-033 Assert Reset_n low at COMPUTE cycle 4 -> outputs zero before the next edge; FSM in IDLE after release.

Source files
------------

// File: rtl/mult_shift_add_seq.sv
// Sequential 8x8 signed shift-add multiplier: A:B holds the 16-bit product,
// built over eight add/subtract-and-shift cycles through a full-adder ripple chain.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// state   | meaning
// IDLE    | waiting; ClearA_LoadB loads B from S, Run starts a multiply
// COMPUTE | eight add/subtract-and-shift iterations, k = 0..7
// HOLD    | product stable until Run is released
module mult_shift_add_seq (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic [7:0] S,
  output logic [7:0] Aval,
  output logic [7:0] Bval,
  output logic       X,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [7:0] a_reg, b_reg, s_reg;
  logic       x_reg;
  logic [2:0] k;

  logic       sub;
  logic [8:0] a_ext, op, sum, xa_post;
  logic [8:0] carry;
  logic       carry_unused;

  // The last iteration weighs the multiplier sign bit negatively, hence subtract.
  assign sub   = (k == 3'd7);
  assign a_ext = {a_reg[7], a_reg};
  assign op    = {s_reg[7], s_reg} ^ {9{sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    full_adder u_fa (
      .a    (a_ext[i]),
      .b    (op[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  full_adder u_fa_msb (
    .a    (a_ext[8]),
    .b    (op[8]),
    .cin  (carry[8]),
    .s    (sum[8]),
    .cout (carry_unused)
  );

  assign xa_post = b_reg[0] ? sum : {x_reg, a_reg};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Run) state_next = COMPUTE;
      COMPUTE: if (k == 3'd7) state_next = HOLD;
      HOLD:    if (!Run) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a_reg <= 8'h00;
      b_reg <= 8'h00;
      s_reg <= 8'h00;
      x_reg <= 1'b0;
      k     <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Run) begin
            s_reg <= S;
            a_reg <= 8'h00;
            x_reg <= 1'b0;
            k     <= 3'd0;
          end else if (ClearA_LoadB) begin
            b_reg <= S;
            a_reg <= 8'h00;
            x_reg <= 1'b0;
          end
        end
        COMPUTE: begin
          x_reg <= xa_post[8];
          a_reg <= xa_post[8:1];
          b_reg <= {xa_post[0], b_reg[7:1]};
          k     <= k + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign Aval = a_reg;
  assign Bval = b_reg;
  assign X    = x_reg;
  assign Busy = (state == COMPUTE);
  assign Done = (state == HOLD);

endmodule

// File: tb/tb_mult_shift_add_seq.sv
// Directed bench for mult_shift_add_seq: hand-computed signed products,
// latency, hold/no-restart, input disturbance in COMPUTE and mid-operation reset.

module tb_mult_shift_add_seq;

  logic       Clk;
  logic       Reset_n;
  logic       Run;
  logic       ClearA_LoadB;
  logic [7:0] S;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       X;
  logic       Busy;
  logic       Done;

  int n_checks = 0;
  int n_fail   = 0;

  mult_shift_add_seq dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .S            (S),
    .Aval         (Aval),
    .Bval         (Bval),
    .X            (X),
    .Busy         (Busy),
    .Done         (Done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_b(input logic [7:0] b);
    S = b;
    ClearA_LoadB = 1'b1;
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    check_val("load", {23'd0, X, Aval, Bval}, {23'd0, 1'b0, 8'h00, b});
  endtask

  task automatic run_op(input logic [7:0] s_op, input logic [15:0] exp_p, input logic exp_x,
                        input int hold, input bit disturb, input bit clr);
    int edges;
    int busy_cnt;
    edges    = 0;
    busy_cnt = 0;
    S = s_op;
    Run = 1'b1;
    ClearA_LoadB = clr;
    while (!Done && edges < 30) begin
      @(negedge Clk);
      edges++;
      if (Busy) busy_cnt++;
      if (Busy && Done) check_val("busy_done_excl", 32'd1, 32'd0);
      if (disturb && Busy) begin
        S = 8'($urandom);
        ClearA_LoadB = 1'($urandom);
      end else begin
        ClearA_LoadB = 1'b0;
      end
    end
    ClearA_LoadB = 1'b0;
    check_val("latency", edges, 9);
    check_val("busy_cycles", busy_cnt, 8);
    check_val("product", {15'd0, X, Aval, Bval}, {15'd0, exp_x, exp_p});
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge Clk);
        if (Busy) busy_cnt++;
      end
      check_val("hold_stable", {14'd0, Busy, Done, X, Aval, Bval}, {14'd0, 1'b0, 1'b1, exp_x, exp_p});
      check_val("busy_total", busy_cnt, 8);
    end
    Run = 1'b0;
    @(negedge Clk);
    check_val("idle_return", {14'd0, Busy, Done, X, Aval, Bval}, {14'd0, 2'b00, exp_x, exp_p});
  endtask

  initial begin
    Reset_n = 1'b1;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    S = 8'h00;
    #2 Reset_n = 1'b0;
    #1 check_val("reset_outputs", {13'd0, Busy, Done, X, Aval, Bval}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check_val("post_reset_idle", {13'd0, Busy, Done, X, Aval, Bval}, 32'd0);

    load_b(8'h03);
    run_op(8'h07, 16'h0015, 1'b0, 0, 1'b0, 1'b0);
    // No reload: B now holds 0x15 (21), times 2.
    run_op(8'h02, 16'h002A, 1'b0, 0, 1'b0, 1'b0);

    load_b(8'hFD);
    run_op(8'h07, 16'hFFEB, 1'b1, 0, 1'b0, 1'b0);
    load_b(8'h80);
    run_op(8'h80, 16'h4000, 1'b0, 0, 1'b0, 1'b0);
    load_b(8'h7F);
    run_op(8'h80, 16'hC080, 1'b1, 0, 1'b0, 1'b0);
    load_b(8'h05);

    // Run held high for 20 cycles in total.
    load_b(8'hFF);
    run_op(8'hFF, 16'h0001, 1'b0, 11, 1'b0, 1'b0);

    load_b(8'hFD);
    run_op(8'h07, 16'hFFEB, 1'b1, 0, 1'b1, 1'b0);

    // Run wins over ClearA_LoadB: 3 * 5, B not reloaded.
    load_b(8'h03);
    run_op(8'h05, 16'h000F, 1'b0, 0, 1'b0, 1'b1);

    load_b(8'hFD);
    S = 8'h07;
    Run = 1'b1;
    repeat (4) @(negedge Clk);
    check_val("busy_before_reset", {31'd0, Busy}, 32'd1);
    Reset_n = 1'b0;
    #1 check_val("reset_mid_compute", {13'd0, Busy, Done, X, Aval, Bval}, 32'd0);
    Run = 1'b0;
    #2 Reset_n = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    check_val("idle_after_abort", {13'd0, Busy, Done, X, Aval, Bval}, 32'd0);
    load_b(8'h03);
    run_op(8'h07, 16'h0015, 1'b0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
